// File: rtl/mod_counter.sv
// Modulo up/down counter with programmable modulus, step, load and terminal-count pulse.
// Latency: 1 clock from any input to out/tc; both outputs are registered.
// Backpressure: none; the counter advances on every enabled edge. Define MOD_COUNTER_SAT_EN for saturating mode.
module mod_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int STEP      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    // One extra bit keeps out+STEP and MAX_COUNT+1 from overflowing.
    localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(MAX_COUNT);
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
`ifndef MOD_COUNTER_SAT_EN
    localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MAX_COUNT + 1);
`endif

    logic [WIDTH-1:0] out_q, out_d;
    logic             tc_q, tc_d;
    logic [WIDTH:0]   cur_x;
    logic [WIDTH:0]   ld_x;

    // Next-state selection in priority load > enabled step > hold (reset handled in the register).
    always_comb begin
        out_d = out_q;
        tc_d  = 1'b0;
        cur_x = {1'b0, out_q};
        ld_x  = {1'b0, load_val};
        if (load) begin
            // Out-of-range load values clamp to the top of the count range.
            out_d = (ld_x > MAX_W) ? MAX_W[WIDTH-1:0] : load_val;
        end else if (en) begin
`ifdef MOD_COUNTER_SAT_EN
            if (up) begin
                if (cur_x >= MAX_W - STEP_W) begin
                    out_d = MAX_W[WIDTH-1:0];
                    tc_d  = 1'b1;
                end else begin
                    out_d = WIDTH'(cur_x + STEP_W);
                end
            end else begin
                if (cur_x <= STEP_W) begin
                    out_d = '0;
                    tc_d  = 1'b1;
                end else begin
                    out_d = WIDTH'(cur_x - STEP_W);
                end
            end
`else
            if (up) begin
                if (cur_x <= MAX_W - STEP_W) begin
                    out_d = WIDTH'(cur_x + STEP_W);
                end else begin
                    out_d = WIDTH'(cur_x + STEP_W - MOD_W);
                    tc_d  = 1'b1;
                end
            end else begin
                if (cur_x >= STEP_W) begin
                    out_d = WIDTH'(cur_x - STEP_W);
                end else begin
                    out_d = WIDTH'(cur_x + MOD_W - STEP_W);
                    tc_d  = 1'b1;
                end
            end
`endif
        end
    end

    // Count and terminal-count registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            tc_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            tc_q  <= tc_d;
        end
    end

    assign out = out_q;
    assign tc  = tc_q;

endmodule
